// File: rtl/num_to_keycodes_if.sv
// Handshake bundle between the number-to-keycode replayer and its user.
// The master side requests conversions and accepts keycodes; the slave
// side is the replayer itself.
interface num_to_keycodes_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) ();
    logic                  start;
    logic [WIDTH-1:0]      number;
    logic                  kc_ready;
    logic                  kc_valid;
    logic [7:0]            keycode;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;

    modport master (
        output start, number, kc_ready,
        input  kc_valid, keycode, bcd, busy, done
    );

    modport slave (
        input  start, number, kc_ready,
        output kc_valid, keycode, bcd, busy, done
    );
endinterface

// File: rtl/num_to_keycodes.sv
// Replays an unsigned binary number as PS/2 set-2 make codes, one per
// decimal digit, most significant digit first, optionally followed by ENTER.
// Binary-to-BCD uses sequential double-dabble, one input bit per clock.
module num_to_keycodes #(
    parameter int WIDTH      = 32,
    parameter int DIGITS     = 10,
    parameter int EMIT_ENTER = 1
) (
    input  logic             clk,
    input  logic             rst,
    num_to_keycodes_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] KC_ENTER = 8'h5A;

    typedef enum logic [2:0] {IDLE, CONV, SCAN, EMIT, TERM, FIN} state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      shift_r;
    logic [4*DIGITS-1:0]   acc_r;
    logic [4*DIGITS-1:0]   bcd_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_dec;
    logic [IDX_W-1:0]      hi_idx;
    logic                  kc_valid_r;
    logic [7:0]            keycode_r;
    logic [4*DIGITS+WIDTH-1:0] step_w;
    logic                  last_bit;
    logic                  xfer;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [4*DIGITS-1:0] dabble_adj(input logic [4*DIGITS-1:0] a);
        logic [4*DIGITS-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // PS/2 set-2 make code of a decimal digit.
    function automatic logic [7:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 8'h45;
            4'd1:    digit_code = 8'h16;
            4'd2:    digit_code = 8'h1E;
            4'd3:    digit_code = 8'h26;
            4'd4:    digit_code = 8'h25;
            4'd5:    digit_code = 8'h2E;
            4'd6:    digit_code = 8'h36;
            4'd7:    digit_code = 8'h3D;
            4'd8:    digit_code = 8'h3E;
            4'd9:    digit_code = 8'h46;
            default: digit_code = 8'h00;
        endcase
    endfunction

    assign step_w   = {dabble_adj(acc_r), shift_r} << 1;
    assign last_bit = (cnt_r == CNT_W'(WIDTH - 1));
    assign xfer     = kc_valid_r && bus.kc_ready;
    assign idx_dec  = idx_r - 1'b1;

    // Locate the most significant nonzero digit; zero value maps to digit 0.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] != 4'd0)
                hi_idx = IDX_W'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        bus.busy   = (state != IDLE);
        bus.done   = (state == FIN);
        case (state)
            IDLE: if (bus.start) state_next = CONV;
            CONV: if (last_bit) state_next = SCAN;
            SCAN: state_next = EMIT;
            EMIT: if (xfer && idx_r == '0)
                      state_next = (EMIT_ENTER != 0) ? TERM : FIN;
            TERM: if (xfer) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath and registered keycode stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r    <= '0;
            acc_r      <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            idx_r      <= '0;
            kc_valid_r <= 1'b0;
            keycode_r  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_r <= bus.number;
                        acc_r   <= '0;
                        bcd_r   <= '0;
                        cnt_r   <= '0;
                    end
                end
                CONV: begin
                    acc_r   <= step_w[4*DIGITS+WIDTH-1:WIDTH];
                    shift_r <= step_w[WIDTH-1:0];
                    cnt_r   <= cnt_r + 1'b1;
                    if (last_bit)
                        bcd_r <= step_w[4*DIGITS+WIDTH-1:WIDTH];
                end
                SCAN: idx_r <= hi_idx;
                EMIT: begin
                    if (!kc_valid_r) begin
                        // First cycle in EMIT loads the leading digit.
                        kc_valid_r <= 1'b1;
                        keycode_r  <= digit_code(bcd_r[4*int'(idx_r) +: 4]);
                    end else if (bus.kc_ready) begin
                        if (idx_r != '0) begin
                            idx_r     <= idx_dec;
                            keycode_r <= digit_code(bcd_r[4*int'(idx_dec) +: 4]);
                        end else if (EMIT_ENTER != 0) begin
                            keycode_r <= KC_ENTER;
                        end else begin
                            kc_valid_r <= 1'b0;
                            keycode_r  <= 8'h00;
                        end
                    end
                end
                TERM: begin
                    if (xfer) begin
                        kc_valid_r <= 1'b0;
                        keycode_r  <= 8'h00;
                    end
                end
                default: begin
                    kc_valid_r <= 1'b0;
                    keycode_r  <= 8'h00;
                end
            endcase
        end
    end

    assign bus.kc_valid = kc_valid_r;
    assign bus.keycode  = keycode_r;
    assign bus.bcd      = bcd_r;
endmodule

// File: tb/tb_num_to_keycodes.sv
// Directed bench for num_to_keycodes: table of numbers with their expected
// keycode streams and BCD, plus hand sequences for stalls, ignored starts
// and an asynchronous reset in the middle of emission.
module tb_num_to_keycodes;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    num_to_keycodes_if #(.WIDTH(32), .DIGITS(10)) bif ();

    num_to_keycodes #(.WIDTH(32), .DIGITS(10), .EMIT_ENTER(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      number;
        int               n;
        logic [0:11][7:0] codes;
        logic [39:0]      bcd;
        bit               stall;
        bit               disturb;
    } vec_t;

    vec_t vt [0:5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion and replay/check the full keycode stream.
    task automatic run_check(input vec_t v, input int id);
        int lat;
        bit seen;
        bif.kc_ready = v.stall ? 1'b0 : 1'b1;
        bif.number   = v.number;
        bif.start    = 1'b1;
        tick();
        bif.start    = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            if (v.disturb && lat == 10) begin
                bif.number = 32'd7;
                bif.start  = 1'b1;
            end
            tick();
            bif.start = 1'b0;
            lat++;
            if (bif.kc_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL vec%0d_timeout actual=no_kc_valid expected=kc_valid", id);
            return;
        end
        check($sformatf("vec%0d_latency", id), 64'(lat), 64'd34);
        for (int j = 0; j < v.n; j++) begin
            check($sformatf("vec%0d_valid%0d", id, j), 64'(bif.kc_valid), 64'd1);
            check($sformatf("vec%0d_code%0d", id, j), 64'(bif.keycode), 64'(v.codes[j]));
            if (v.stall) begin
                bif.kc_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check($sformatf("vec%0d_hold%0d", id, j),
                          {55'd0, bif.kc_valid, bif.keycode}, {55'd0, 1'b1, v.codes[j]});
                end
                bif.kc_ready = 1'b1;
                tick();
                bif.kc_ready = 1'b0;
            end else begin
                if (v.disturb && j == 1) bif.start = 1'b1;
                tick();
                bif.start = 1'b0;
            end
        end
        check($sformatf("vec%0d_done", id), 64'(bif.done), 64'd1);
        check($sformatf("vec%0d_fin_valid", id), {55'd0, bif.kc_valid, bif.keycode}, 64'd0);
        check($sformatf("vec%0d_bcd", id), 64'(bif.bcd), 64'(v.bcd));
        if (v.disturb) begin
            bif.number = 32'd7;
            bif.start  = 1'b1;
        end
        tick();
        bif.start = 1'b0;
        check($sformatf("vec%0d_done_pulse", id), 64'(bif.done), 64'd0);
        check($sformatf("vec%0d_idle", id), 64'(bif.busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v9;
        bit   seen;
        checks   = 0;
        failures = 0;

        vt[0] = '{32'd0, 2, {8'h45, 8'h5A, 80'h0}, 40'h0, 1'b0, 1'b0};
        vt[1] = '{32'd1234, 5, {8'h16, 8'h1E, 8'h26, 8'h25, 8'h5A, 56'h0},
                  40'h1234, 1'b0, 1'b0};
        vt[2] = '{32'hFFFF_FFFF, 11, {8'h25, 8'h1E, 8'h46, 8'h25, 8'h46, 8'h36,
                  8'h3D, 8'h1E, 8'h46, 8'h2E, 8'h5A, 8'h0}, 40'h42_9496_7295, 1'b0, 1'b0};
        vt[3] = '{32'd1002, 5, {8'h16, 8'h45, 8'h45, 8'h1E, 8'h5A, 56'h0},
                  40'h1002, 1'b1, 1'b0};
        vt[4] = '{32'd1234, 5, {8'h16, 8'h1E, 8'h26, 8'h25, 8'h5A, 56'h0},
                  40'h1234, 1'b0, 1'b1};
        vt[5] = '{32'd50, 3, {8'h2E, 8'h45, 8'h5A, 72'h0}, 40'h50, 1'b0, 1'b0};
        v9    = '{32'd9, 2, {8'h46, 8'h5A, 80'h0}, 40'h9, 1'b0, 1'b0};

        rst          = 1'b1;
        bif.start    = 1'b0;
        bif.number   = '0;
        bif.kc_ready = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {20'd0, bif.kc_valid, bif.keycode, bif.busy, bif.done, 33'd0},
              64'd0);
        check("reset_bcd", 64'(bif.bcd), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_check(vt[i], i);

        // Asynchronous reset between edges while a code is being presented.
        bif.kc_ready = 1'b0;
        bif.number   = 32'd1234;
        bif.start    = 1'b1;
        tick();
        bif.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (bif.kc_valid) seen = 1'b1;
        end
        check("rst_pre_valid", 64'(seen), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bif.kc_valid), 64'd0);
        check("rst_async_keycode", 64'(bif.keycode), 64'd0);
        check("rst_async_busy", 64'(bif.busy), 64'd0);
        check("rst_async_bcd", 64'(bif.bcd), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_idle", 64'(bif.busy), 64'd0);
        run_check(v9, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
